// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo_sync_flex family.
//   ptr_w()          : pointer width for a given depth (index bits + wrap bit)
//   is_pow2()        : power-of-two test used by the elaboration checks
//   FIFO_MODE_*      : read-mode selector values for the FWFT parameter
//   FIFO_ELAB_CHECK  : elaboration-time parameter range assertion
`ifndef FIFO_PKG_MACROS_SV
`define FIFO_PKG_MACROS_SV
`define FIFO_ELAB_CHECK(lbl, cond, msg) \
  if (!(cond)) begin : lbl \
    $error(msg); \
  end
`endif

package fifo_pkg;

  localparam int unsigned FIFO_MODE_REG  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// WIDTH x DEPTH storage array for fifo_sync_flex. No reset.
//   clk     : write clock
//   wr_en   : write strobe, wr_data stored at wr_addr on the rising edge
//   wr_addr : write index
//   wr_data : write word
//   rd_addr : read index
//   rd_data : asynchronous read of mem[rd_addr]
module fifo_mem_dp #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = mem_q[rd_addr];
  end

endmodule

// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO with selectable read mode (registered / FWFT),
// programmable almost-full / almost-empty thresholds, occupancy count and
// single-cycle overflow / underflow pulses.
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   wr_en/wr_data : write request and word; dropped while full
//   full          : no free entry
//   almost_full   : count >= AFULL_TH
//   overflow      : one cycle after a write requested while full
//   rd_en         : read request (FWFT: acknowledge the presented word)
//   rd_data       : read word (registered mode: cycle after accept)
//   empty         : no readable word
//   almost_empty  : count <= AEMPTY_TH
//   underflow     : one cycle after a read requested while empty
//   count         : occupancy, 0..DEPTH
module fifo_sync_flex
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned FWFT      = FIFO_MODE_REG,
  parameter int unsigned AFULL_TH  = DEPTH - 2,
  parameter int unsigned AEMPTY_TH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   full,
  output logic                   almost_full,
  output logic                   overflow,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic                   almost_empty,
  output logic                   underflow,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned AW    = PTR_W - 1;

  localparam logic [PTR_W-1:0] AFULL_C  = PTR_W'(AFULL_TH);
  localparam logic [PTR_W-1:0] AEMPTY_C = PTR_W'(AEMPTY_TH);

  `FIFO_ELAB_CHECK(g_chk_width, WIDTH >= 1, "fifo_sync_flex: WIDTH must be >= 1")
  `FIFO_ELAB_CHECK(g_chk_depth, is_pow2(DEPTH) && DEPTH >= 2, "fifo_sync_flex: DEPTH must be a power of two >= 2")
  `FIFO_ELAB_CHECK(g_chk_mode, FWFT <= FIFO_MODE_FWFT, "fifo_sync_flex: FWFT must be 0 or 1")
  `FIFO_ELAB_CHECK(g_chk_afull, AFULL_TH >= 1 && AFULL_TH <= DEPTH, "fifo_sync_flex: AFULL_TH out of range 1..DEPTH")
  `FIFO_ELAB_CHECK(g_chk_aempty, AEMPTY_TH <= DEPTH - 1, "fifo_sync_flex: AEMPTY_TH out of range 0..DEPTH-1")

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_accept, rd_accept;
  logic [WIDTH-1:0] mem_rd_data;

  // Wrap bit distinguishes full from empty when the index bits coincide.
  always_comb begin
    empty        = (wr_ptr_q == rd_ptr_q);
    full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    count        = wr_ptr_q - rd_ptr_q;
    almost_full  = (count >= AFULL_C);
    almost_empty = (count <= AEMPTY_C);
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

  always_comb begin
    wr_accept   = wr_en && !full;
    rd_accept   = rd_en && !empty;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;
    overflow_d  = wr_en && full;
    underflow_d = rd_en && empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem_dp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (mem_rd_data)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // Head word is shown directly; forced to zero while empty so the
    // output reads as the reset value when nothing is stored.
    always_comb begin
      rd_data = empty ? '0 : mem_rd_data;
    end
  end else begin : g_reg
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    always_comb begin
      rd_data_d = rd_data_q;
      if (rd_accept) rd_data_d = mem_rd_data;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data_q <= '0;
      end else begin
        rd_data_q <= rd_data_d;
      end
    end

    always_comb begin
      rd_data = rd_data_q;
    end
  end

endmodule

// File: tb/tb_fifo_sync_flex.sv
// Bench for fifo_sync_flex: a registered-read and an FWFT instance
// (WIDTH=16, DEPTH=4, AFULL_TH=3, AEMPTY_TH=1) share one stimulus stream
// and are compared against a queue-based reference model.
module tb_fifo_sync_flex;

  localparam int unsigned W = 16;
  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic rst;
  logic wr_en, rd_en;
  logic [W-1:0] wr_data;

  logic         r_full, r_afull, r_ovf, r_empty, r_aempty, r_udf;
  logic [W-1:0] r_rd_data;
  logic [2:0]   r_count;
  logic         f_full, f_afull, f_ovf, f_empty, f_aempty, f_udf;
  logic [W-1:0] f_rd_data;
  logic [2:0]   f_count;

  always #5 clk = ~clk;

  fifo_sync_flex #(
    .WIDTH (W), .DEPTH (D), .FWFT (0), .AFULL_TH (3), .AEMPTY_TH (1)
  ) u_reg (
    .clk (clk), .rst (rst),
    .wr_en (wr_en), .wr_data (wr_data),
    .full (r_full), .almost_full (r_afull), .overflow (r_ovf),
    .rd_en (rd_en), .rd_data (r_rd_data),
    .empty (r_empty), .almost_empty (r_aempty), .underflow (r_udf),
    .count (r_count)
  );

  fifo_sync_flex #(
    .WIDTH (W), .DEPTH (D), .FWFT (1), .AFULL_TH (3), .AEMPTY_TH (1)
  ) u_fwft (
    .clk (clk), .rst (rst),
    .wr_en (wr_en), .wr_data (wr_data),
    .full (f_full), .almost_full (f_afull), .overflow (f_ovf),
    .rd_en (rd_en), .rd_data (f_rd_data),
    .empty (f_empty), .almost_empty (f_aempty), .underflow (f_udf),
    .count (f_count)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] exp_rd  = '0;
  logic         exp_ovf = 1'b0;
  logic         exp_udf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int unsigned sz;
    sz = q.size();
    check("r_count",  32'(r_count),  sz);
    check("r_empty",  32'(r_empty),  32'(sz == 0));
    check("r_full",   32'(r_full),   32'(sz == D));
    check("r_afull",  32'(r_afull),  32'(sz >= 3));
    check("r_aempty", 32'(r_aempty), 32'(sz <= 1));
    check("r_ovf",    32'(r_ovf),    32'(exp_ovf));
    check("r_udf",    32'(r_udf),    32'(exp_udf));
    check("r_rd_data", 32'(r_rd_data), 32'(exp_rd));
    check("f_count",  32'(f_count),  sz);
    check("f_empty",  32'(f_empty),  32'(sz == 0));
    check("f_full",   32'(f_full),   32'(sz == D));
    check("f_afull",  32'(f_afull),  32'(sz >= 3));
    check("f_aempty", 32'(f_aempty), 32'(sz <= 1));
    check("f_ovf",    32'(f_ovf),    32'(exp_ovf));
    check("f_udf",    32'(f_udf),    32'(exp_udf));
    if (sz != 0) check("f_rd_data", 32'(f_rd_data), 32'(q[0]));
  endtask

  // One clock of traffic; the model applies the acceptance rules to the
  // occupancy seen before the edge.
  task automatic step(input logic we, input logic [W-1:0] wd, input logic re);
    bit was_full, was_empty;
    wr_en = we; wr_data = wd; rd_en = re;
    @(posedge clk);
    was_full  = (q.size() == D);
    was_empty = (q.size() == 0);
    if (re && !was_empty) exp_rd = q.pop_front();
    if (we && !was_full)  q.push_back(wd);
    exp_ovf = we && was_full;
    exp_udf = re && was_empty;
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
    check_all();
  endtask

  initial begin
    logic [W-1:0] base;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Fill to full, then one write too many.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 16'hA001 + 16'(i), 1'b0);
      check("fill_count", 32'(r_count), 32'(i + 1));
    end
    check("fill_full", 32'(r_full), 32'd1);
    step(1'b1, 16'hA005, 1'b0);
    check("ovf_pulse", 32'(r_ovf), 32'd1);
    check("ovf_count", 32'(r_count), 32'd4);
    step(1'b0, '0, 1'b0);
    check("ovf_clear", 32'(r_ovf), 32'd0);

    // Drain in registered mode, then one read too many.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1);
      check("drain_data", 32'(r_rd_data), 32'(16'hA001 + 16'(i)));
    end
    check("drain_empty", 32'(r_empty), 32'd1);
    step(1'b0, '0, 1'b1);
    check("udf_pulse", 32'(r_udf), 32'd1);
    check("udf_hold", 32'(r_rd_data), 32'h0000A004);

    // FWFT presentation without rd_en.
    step(1'b1, 16'hB001, 1'b0);
    check("fwft_present", 32'(f_rd_data), 32'h0000B001);
    check("fwft_nonempty", 32'(f_empty), 32'd0);
    step(1'b0, '0, 1'b1);
    check("fwft_pop_empty", 32'(f_empty), 32'd1);

    // Steady simultaneous traffic at count=2 across pointer wraps.
    step(1'b1, 16'h1111, 1'b0);
    step(1'b1, 16'h2222, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'hD000 + 16'(i), 1'b1);
      check("sim_count", 32'(r_count), 32'd2);
    end
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    check("sim_last", 32'(r_rd_data), 32'h0000D009);

    // Simultaneous read/write while full.
    for (int i = 0; i < 4; i++) step(1'b1, 16'hE000 + 16'(i), 1'b0);
    step(1'b1, 16'hEEEE, 1'b1);
    check("full_rw_ovf", 32'(r_ovf), 32'd1);
    check("full_rw_cnt", 32'(r_count), 32'd3);
    check("full_rw_data", 32'(r_rd_data), 32'h0000E000);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);

    // Simultaneous read/write while empty.
    step(1'b1, 16'h5A5A, 1'b1);
    check("empty_rw_udf", 32'(r_udf), 32'd1);
    check("empty_rw_cnt", 32'(r_count), 32'd1);
    step(1'b0, '0, 1'b1);
    check("empty_rw_data", 32'(r_rd_data), 32'h00005A5A);

    // Random traffic, alternating fill-biased and drain-biased phases.
    for (int i = 0; i < 400; i++) begin
      int unsigned pw;
      pw = ((i / 50) % 2 == 0) ? 70 : 30;
      base = 16'($urandom);
      step($urandom_range(0, 99) < pw, base, $urandom_range(0, 99) >= pw);
    end

    // Asynchronous reset between edges with count=3.
    while (q.size() > 0) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 16'h7000 + 16'(i), 1'b0);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    exp_rd = '0; exp_ovf = 1'b0; exp_udf = 1'b0;
    check_all();
    check("arst_rd_data", 32'(r_rd_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 16'hC0DE, 1'b0);
    check("arst_fwft", 32'(f_rd_data), 32'h0000C0DE);
    step(1'b0, '0, 1'b1);
    check("arst_roundtrip", 32'(r_rd_data), 32'h0000C0DE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
